// File: rtl/cache_assoc.sv
// Set-associative write-back/write-allocate cache with a single next-level line port.
// Latency: hits complete combinationally in IDLE; misses stall until one cycle after the final mem_ack.
// Backpressure: stall holds the CPU pipeline; mem_* outputs stay stable until mem_ack, with no timeout.
module cache_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_index,
  input  logic                    write_index,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [WORDS*DATA_W-1:0] mem_rdata
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LSB   = OFF_W + 2;
  localparam int TAG_W = ADDR_W - IDX_W - LSB;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             req;
  logic             unused_addr_bits;

  assign offset           = addr[LSB-1:2];
  assign idx              = addr[LSB +: IDX_W];
  assign req_tag          = addr[ADDR_W-1 -: TAG_W];
  assign req              = read_index | write_index;
  assign unused_addr_bits = ^addr[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             invalid_found;
  logic [WAY_W-1:0] victim_q;
  logic [WORDS*DATA_W-1:0] victim_line;

  logic store_hit, wb_done, refill_done;

  assign store_hit   = (state_q == IDLE) && req && hit && write_index;
  assign wb_done     = (state_q == WRITEBACK) && mem_ack;
  assign refill_done = (state_q == REFILL) && mem_ack;

  // Tag compare across all ways of the addressed set; lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    victim        = rr_q[idx];
    invalid_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!invalid_found && !valid_q[idx][w]) begin
        invalid_found = 1'b1;
        victim        = WAY_W'(w);
      end
    end
  end

  // Flatten the victim line for write-back, word 0 in the LSBs.
  always_comb begin
    victim_line = '0;
    for (int k = 0; k < WORDS; k++) begin
      victim_line[k*DATA_W +: DATA_W] = data_q[victim_q][idx][k];
    end
  end

  // State register and the victim way latched when a miss is detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && !hit) begin
        victim_q <= victim;
      end
    end
  end

  // Next-state and all CPU/memory-side outputs; mem_* are zero whenever idle.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    read_data = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            read_data = data_q[hit_way][idx][offset];
          end else begin
            stall   = 1'b1;
            state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_q][idx], idx, {LSB{1'b0}}};
        mem_wdata = victim_line;
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, {LSB{1'b0}}};
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line status: valid/dirty bits and round-robin pointers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (store_hit) dirty_q[idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (refill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        rr_q[idx]              <= (WAYS > 1) ? rr_q[idx] + 1'b1 : '0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (store_hit) begin
      data_q[hit_way][idx][offset] <= write_data;
    end
    if (refill_done) begin
      tag_q[victim_q][idx] <= req_tag;
      for (int k = 0; k < WORDS; k++) begin
        data_q[victim_q][idx][k] <= mem_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: table of single-cycle hit vectors plus hand-written miss sequences.
// Load results are queued when a request is driven and compared when stall drops.
// The bench plays the next-level memory, checking request fields before acknowledging.
module tb_cache_assoc;
  logic          clk = 1'b0;
  logic          rst;
  logic          read_index, write_index;
  logic [31:0]   addr, write_data, read_data, mem_addr;
  logic          stall, mem_req, mem_we, mem_ack;
  logic [127:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  localparam logic [127:0] L100    = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] L100_WB = {32'h44, 32'h33, 32'hDEADBEEF, 32'h11};
  localparam logic [127:0] L200    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L300    = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] L400    = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] L500    = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
  localparam logic [127:0] L500_WB = {32'hE3, 32'hE2, 32'hE1, 32'h5};
  localparam logic [127:0] L600    = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
  localparam logic [127:0] L700    = {32'h73, 32'h72, 32'h71, 32'h70};

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  cache_assoc dut (
    .clk(clk), .rst(rst),
    .read_index(read_index), .write_index(write_index),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    read_index  = r;
    write_index = w;
    addr        = a;
    write_data  = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Start a request on a fresh cycle and queue the load value it should return.
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp);
    tick();
    drive(r, w, a, wd);
    exp_q.push_back(exp);
  endtask

  // Wait (bounded) for stall to drop, then compare read_data against the queue head.
  task automatic complete(input string nm);
    int n = 0;
    logic [31:0] exp;
    while (stall && n < 50) begin
      tick();
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    if (stall) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall still %0b after %0d cycles, required 0", nm, stall, n);
    end else begin
      check(nm, read_data, exp);
    end
  endtask

  // Next-level memory: wait for mem_req, check it, hold for delay cycles, then ack.
  task automatic serve(input string nm, input logic we, input logic [31:0] a,
                       input logic [127:0] wline, input logic [127:0] rline, input int delay);
    int n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_req"}, mem_req, 1'b1);
    check({nm, "_we"}, mem_we, we);
    check({nm, "_addr"}, mem_addr, a);
    check({nm, "_stall"}, stall, 1'b1);
    if (we) check({nm, "_wdata"}, mem_wdata, wline);
    repeat (delay) tick();
    if (delay > 0) check({nm, "_hold"}, mem_addr, a);
    mem_ack   = 1'b1;
    mem_rdata = rline;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h10C, 32'h0,        1'b0, 32'h44};
    vecs[1] = '{1'b1, 1'b0, 32'h108, 32'h0,        1'b0, 32'h33};
    vecs[2] = '{1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h22};
    vecs[3] = '{1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h11};

    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    idle();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_read_data", read_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold read miss, refill acknowledged after 3 cycles.
    req(1'b1, 1'b0, 32'h100, 32'h0, 32'h11);
    check("cold_stall", stall, 1'b1);
    check("cold_idle_no_req", mem_req, 1'b0);
    serve("cold", 1'b0, 32'h100, '0, L100, 3);
    complete("cold_rd");

    // Hits on the resident line, including a load+store treated as a store.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rdata);
    end

    // Fill way 1, then evict the dirty way 0 line.
    req(1'b1, 1'b0, 32'h200, 32'h0, 32'hA0);
    serve("r200", 1'b0, 32'h200, '0, L200, 1);
    complete("r200_rd");
    req(1'b1, 1'b0, 32'h300, 32'h0, 32'hB0);
    check("r300_stall", stall, 1'b1);
    serve("wb100", 1'b1, 32'h100, L100_WB, '0, 2);
    serve("r300", 1'b0, 32'h300, '0, L300, 0);
    complete("r300_rd");
    tick();
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    check("r100_evicted_stall", stall, 1'b1);
    idle();
    req(1'b1, 1'b0, 32'h200, 32'h0, 32'hA0);
    check("r200_kept_stall", stall, 1'b0);
    complete("r200_kept_rd");

    // Stray ack in IDLE with no request must change nothing.
    tick();
    idle();
    mem_ack   = 1'b1;
    mem_rdata = {4{32'hFFFFFFFF}};
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("stray_ack_mem_req", mem_req, 1'b0);
    check("stray_ack_stall", stall, 1'b0);
    check("stray_ack_rdata", read_data, 32'h0);
    req(1'b1, 1'b0, 32'h300, 32'h0, 32'hB0);
    check("stray_ack_hit_stall", stall, 1'b0);
    complete("stray_ack_r300");

    // Reset in REFILL abandons the transfer; a late ack is ignored.
    tick();
    drive(1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    check("r400_refill_req", mem_req, 1'b1);
    check("r400_refill_addr", mem_addr, 32'h400);
    tick();
    rst = 1'b1;
    #1;
    check("rst_refill_mem_req", mem_req, 1'b0);
    check("rst_refill_mem_addr", mem_addr, 32'h0);
    check("rst_refill_stall", stall, 1'b1);
    tick();
    rst = 1'b0;
    idle();
    mem_ack   = 1'b1;
    mem_rdata = L400;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("late_ack_mem_req", mem_req, 1'b0);
    req(1'b1, 1'b0, 32'h400, 32'h0, 32'hC0);
    check("r400_again_stall", stall, 1'b1);
    serve("r400", 1'b0, 32'h400, '0, L400, 1);
    complete("r400_rd");

    // Cold load+store allocates, then proves the line dirty by evicting it.
    req(1'b1, 1'b1, 32'h500, 32'h5, 32'hE0);
    check("st500_stall", stall, 1'b1);
    serve("st500", 1'b0, 32'h500, '0, L500, 1);
    complete("st500_pre");
    req(1'b1, 1'b0, 32'h500, 32'h0, 32'h5);
    check("r500_stall", stall, 1'b0);
    complete("r500_rd");
    req(1'b1, 1'b0, 32'h600, 32'h0, 32'hF0);
    serve("r600", 1'b0, 32'h600, '0, L600, 0);
    complete("r600_rd");
    req(1'b1, 1'b0, 32'h700, 32'h0, 32'h70);
    serve("wb500", 1'b1, 32'h500, L500_WB, '0, 1);
    serve("r700", 1'b0, 32'h700, '0, L700, 1);
    complete("r700_rd");

    tick();
    idle();
    check("queue_drained", 128'(exp_q.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
